mfp_audio_seq: RTL

MFP_AUDIO_SEQ -- requirements
Module: mfp_audio_seq

---
 rtl/mfp_audio_seq.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mfp_audio_seq.sv
// Note sequencer that arbitrates five one-shot sound effects over a looping music track.
// Optional build macro MFP_AUDIO_SFX_PREEMPT_EN lets a higher-index sfx abort a playing lower one.
//
// state | meaning
// IDLE  | silent, waiting for a pending sfx or music_en
// ARB   | choose highest pending sfx, else music, else back to IDLE
// FETCH | rom_addr driven with the note pointer
// WAIT  | ROM word arrives; captured on the next edge
// PLAY  | tone output for dur ticks, then advance, loop or re-arbitrate
module mfp_audio_seq #(
  parameter int unsigned TICK_DIV   = 250000,
  parameter logic [6:0]  MUSIC_BASE = 7'h40
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [4:0]  sfx_req,
  input  logic        music_en,
  output logic [6:0]  rom_addr,
  input  logic [24:0] rom_data,
  output logic [15:0] tone_half_period,
  output logic        tone_en,
  output logic [2:0]  active_id
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_FETCH, S_WAIT, S_PLAY} state_t;

  state_t      state, state_nxt;
  logic [4:0]  pending, pend_clr, req_all;
  logic [6:0]  ptr, ptr_nxt, music_ptr, music_ptr_nxt;
  logic        cur_music, cur_music_nxt;
  logic [2:0]  cur_sfx, cur_sfx_nxt, top_sfx;
  logic [PW-1:0] presc;
  logic [7:0]  ticks_left;
  logic        note_last;
  logic        tick, play_end, any_pend, sfx_hit, last_entry;

  assign tick       = (presc == '0);
  assign any_pend   = |pending;
  assign req_all    = pending | sfx_req;
  assign sfx_hit    = |req_all;
  assign play_end   = tick && (ticks_left == 8'd1);
  // sfx never leaves its 8-entry window; music wraps at the top of the ROM
  assign last_entry = note_last || (cur_music ? (ptr == 7'h7F) : (ptr[2:0] == 3'd7));

  always_comb begin
    top_sfx = 3'd0;
    for (int i = 0; i < 5; i++)
      if (pending[i]) top_sfx = 3'(i);
  end

`ifdef MFP_AUDIO_SFX_PREEMPT_EN
  logic hi_req;
  always_comb begin
    hi_req = 1'b0;
    for (int i = 0; i < 5; i++)
      if (req_all[i] && (3'(i) > cur_sfx)) hi_req = 1'b1;
  end
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_pend || music_en) state_nxt = S_ARB;
      S_ARB:   state_nxt = (any_pend || music_en) ? S_FETCH : S_IDLE;
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_PLAY;
      S_PLAY: begin
        if (cur_music) begin
          if (sfx_hit)        state_nxt = S_ARB;
          else if (!music_en) state_nxt = S_IDLE;
          else if (play_end)  state_nxt = S_FETCH;
        end else begin
          if (play_end) state_nxt = last_entry ? S_ARB : S_FETCH;
`ifdef MFP_AUDIO_SFX_PREEMPT_EN
          if (hi_req) state_nxt = S_ARB;
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_nxt       = ptr;
    music_ptr_nxt = music_ptr;
    pend_clr      = '0;
    cur_music_nxt = cur_music;
    cur_sfx_nxt   = cur_sfx;
    case (state)
      S_ARB: begin
        if (any_pend) begin
          pend_clr      = 5'b00001 << top_sfx;
          ptr_nxt       = {1'b0, top_sfx, 3'b000};
          cur_music_nxt = 1'b0;
          cur_sfx_nxt   = top_sfx;
        end else if (music_en) begin
          ptr_nxt       = music_ptr;
          cur_music_nxt = 1'b1;
        end
      end
      S_PLAY: begin
        if (state_nxt == S_FETCH)
          ptr_nxt = (cur_music && last_entry) ? MUSIC_BASE : ptr + 7'd1;
        else if (cur_music && (state_nxt != S_PLAY))
          music_ptr_nxt = ptr;
      end
      default: ;
    endcase
  end

  // Prescaler restarts on PLAY entry so every note lasts whole ticks.
  always_ff @(posedge HCLK) begin
    if (HRESET)                         presc <= '0;
    else if (state == S_WAIT || tick)   presc <= PRESC_TOP;
    else                                presc <= presc - PW'(1);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pending          <= '0;
      ptr              <= '0;
      music_ptr        <= MUSIC_BASE;
      cur_music        <= 1'b0;
      cur_sfx          <= '0;
      ticks_left       <= '0;
      note_last        <= 1'b0;
      tone_en          <= 1'b0;
      tone_half_period <= '0;
      active_id        <= '0;
      rom_addr         <= '0;
    end else begin
      pending   <= (pending & ~pend_clr) | sfx_req;
      ptr       <= ptr_nxt;
      music_ptr <= music_ptr_nxt;
      cur_music <= cur_music_nxt;
      cur_sfx   <= cur_sfx_nxt;

      if (state_nxt == S_FETCH) begin
        rom_addr  <= ptr_nxt;
        active_id <= cur_music_nxt ? 3'd1 : cur_sfx_nxt + 3'd2;
      end else if (state_nxt == S_IDLE) begin
        active_id <= '0;
      end

      if (state == S_WAIT) begin
        note_last        <= rom_data[24];
        tone_half_period <= rom_data[23:8];
        ticks_left       <= (rom_data[7:0] == 8'd0) ? 8'd1 : rom_data[7:0];
        tone_en          <= (rom_data[23:8] != 16'd0);
      end else begin
        if (state_nxt != S_PLAY) tone_en <= 1'b0;
        if (state == S_PLAY && tick) ticks_left <= ticks_left - 8'd1;
      end
    end
  end

endmodule
